// File: rtl/riscv_mem_arbiter.sv
// Lets the instruction-fetch port and the data port share one single-ported memory.
// One transaction in flight; data wins ties until the anti-starvation counter saturates.
module riscv_mem_arbiter #(
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    logic [SW-1:0] r_d_streak;
    logic [TW-1:0] r_timer;
    logic          r_owner_d;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic          r_i_done;
    logic [31:0]   r_i_rdata;
    logic          r_d_done;
    logic [31:0]   r_d_rdata;
    logic          r_err;

    logic          w_grant_d;
    logic          w_timeout;
    logic          w_rvalid_ok;
    logic          w_finish;
    logic [31:0]   w_fin_data;

    assign w_grant_d   = d_req && (!i_req || (r_d_streak != STREAK_MAX));
    assign w_timeout   = (r_timer == TIMER_LAST);
    assign w_rvalid_ok = (r_state == S_WAIT) && mem_rvalid;
    // A completion on the last allowed cycle beats the timeout.
    assign w_finish    = w_rvalid_ok ||
                         (((r_state == S_REQ) || (r_state == S_WAIT)) && w_timeout);
    assign w_fin_data  = (w_rvalid_ok && !r_mem_we) ? mem_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_d_streak  <= '0;
            r_timer     <= '0;
            r_owner_d   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_i_done    <= 1'b0;
            r_i_rdata   <= '0;
            r_d_done    <= 1'b0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (d_req || i_req) begin
                        r_state   <= S_REQ;
                        r_timer   <= '0;
                        r_mem_req <= 1'b1;
                        if (w_grant_d) begin
                            r_owner_d   <= 1'b1;
                            r_mem_we    <= d_we;
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                            r_mem_be    <= d_be;
                            // Streak only grows while a fetch is being held off.
                            if (!i_req)
                                r_d_streak <= '0;
                            else if (r_d_streak != STREAK_MAX)
                                r_d_streak <= r_d_streak + SW'(1);
                        end else begin
                            r_owner_d   <= 1'b0;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= i_addr;
                            r_mem_wdata <= '0;
                            r_mem_be    <= 4'hF;
                            r_d_streak  <= '0;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    if (w_finish) begin
                        r_state   <= S_RESP;
                        r_mem_req <= 1'b0;
                        r_i_done  <= !r_owner_d;
                        r_d_done  <= r_owner_d;
                        r_i_rdata <= r_owner_d ? 32'h0 : w_fin_data;
                        r_d_rdata <= r_owner_d ? w_fin_data : 32'h0;
                        r_err     <= !w_rvalid_ok;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                        if ((r_state == S_REQ) && mem_gnt) begin
                            r_state   <= S_WAIT;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_i_done  <= 1'b0;
                    r_d_done  <= 1'b0;
                    r_i_rdata <= '0;
                    r_d_rdata <= '0;
                    r_err     <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: table of single transactions plus hand-built
// collision, starvation, stray-rvalid and mid-transaction reset sequences.
module tb_riscv_mem_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        i_done, d_done, err;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } rq_t;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          gap;
    } exp_t;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gnt_lat;
        int          rv_lat;
        logic        never;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    rq_t  iq[$];
    rq_t  dq[$];
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_rise = -1;

    int          cfg_gnt_lat = 0;
    int          cfg_rv_lat  = 0;
    bit          cfg_never   = 0;
    bit          cfg_stray   = 0;
    bit          m_in_wait   = 0;
    int          m_req_cnt   = 0;
    int          m_wait_cnt  = 0;
    logic [31:0] m_addr      = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return (a ^ 32'hC0DE_0000) + 32'h1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: grant after cfg_gnt_lat REQ cycles, rvalid cfg_rv_lat WAIT cycles later.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (rst || i_done || d_done) begin
                m_in_wait = 0;
                m_req_cnt = 0;
            end
            if (m_in_wait) begin
                if (m_wait_cnt == cfg_rv_lat) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = memval(m_addr);
                    m_in_wait  = 0;
                end else begin
                    m_wait_cnt++;
                end
            end else begin
                if (mem_req) begin
                    if (!cfg_never && m_req_cnt == cfg_gnt_lat) begin
                        mem_gnt    = 1'b1;
                        m_in_wait  = 1;
                        m_wait_cnt = 0;
                        m_addr     = mem_addr;
                        m_req_cnt  = 0;
                    end else begin
                        m_req_cnt++;
                    end
                end else begin
                    m_req_cnt = 0;
                end
                if (cfg_stray) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hDEAD_BEEF;
                end
            end
        end
    end

    task automatic push_txn(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input bit e, input int lat, input int gap);
        rq_t  r;
        exp_t x;
        r.we    = is_d ? we : 1'b0;
        r.addr  = addr;
        r.wdata = is_d ? wdata : 32'h0;
        r.be    = is_d ? be : 4'hF;
        x.is_d  = is_d;
        x.we    = r.we;
        x.addr  = addr;
        x.wdata = r.wdata;
        x.be    = r.be;
        x.rdata = (e || r.we) ? 32'h0 : memval(addr);
        x.err   = e;
        x.lat   = lat;
        x.gap   = gap;
        if (is_d) dq.push_back(r);
        else iq.push_back(r);
        sb.push_back(x);
    endtask

    task automatic drive_heads();
        if (iq.size() > 0) begin
            i_req = 1'b1; i_addr = iq[0].addr;
        end else begin
            i_req = 1'b0; i_addr = '0;
        end
        if (dq.size() > 0) begin
            d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr;
            d_wdata = dq[0].wdata; d_be = dq[0].be;
        end else begin
            d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        end
    endtask

    task automatic run_loop();
        int start_rise = 0;
        int last_rise  = -1;
        bit prev       = 0;
        int budget     = 0;
        while (sb.size() > 0 && budget < 200) begin
            @(negedge clk);
            budget++;
            if (mem_req) begin
                if (!prev) begin
                    if (first_rise < 0) first_rise = cyc;
                    if (sb[0].gap > 0 && last_rise >= 0)
                        chk("issue_gap", cyc - last_rise, sb[0].gap);
                    last_rise  = cyc;
                    start_rise = cyc;
                end
                chk("mem_addr", mem_addr, sb[0].addr);
                chk("mem_we_be", {mem_we, mem_be}, {sb[0].we, sb[0].be});
                chk("mem_wdata", mem_wdata, sb[0].wdata);
            end
            prev = mem_req;
            if (i_done || d_done) begin
                $display("txn %s addr=%08h rdata=%08h err=%0d lat=%0d",
                         sb[0].is_d ? (sb[0].we ? "ST" : "LD") : "IF",
                         sb[0].addr, sb[0].is_d ? d_rdata : i_rdata, err, cyc - start_rise);
                chk("done_owner", {i_done, d_done}, sb[0].is_d ? 2'b01 : 2'b10);
                chk("rdata", sb[0].is_d ? d_rdata : i_rdata, sb[0].rdata);
                chk("other_rdata", sb[0].is_d ? i_rdata : d_rdata, 32'h0);
                chk("err", err, sb[0].err);
                chk("latency", cyc - start_rise, sb[0].lat);
                chk("mem_req_in_resp", mem_req, 0);
                void'(sb.pop_front());
                if (d_done && dq.size() > 0) void'(dq.pop_front());
                else if (i_done && iq.size() > 0) void'(iq.pop_front());
                drive_heads();
            end else begin
                chk("quiet_outputs", {err, |i_rdata, |d_rdata}, 0);
            end
        end
        if (sb.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: %0d transactions outstanding after %0d cycles", sb.size(), budget);
            sb.delete(); iq.delete(); dq.delete();
            drive_heads();
        end
        repeat (2) begin
            @(negedge clk);
            chk("no_regrant", {mem_req, i_done, d_done}, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    vec_t vecs[10];

    initial begin
        int t0;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,          4'hF,    0, 0, 1'b0, 1'b0, 2};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,          4'hF,    0, 0, 1'b0, 1'b0, 2};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0044, 32'hAABB_CCDD,  4'b0011, 0, 0, 1'b0, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,          4'hF,    2, 1, 1'b0, 1'b0, 5};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,          4'hF,    1, 3, 1'b0, 1'b0, 6};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,          4'hF,    0, 0, 1'b1, 1'b1, 8};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,          4'hF,    0, 6, 1'b0, 1'b0, 8};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,          4'hF,    0, 7, 1'b0, 1'b1, 8};
        vecs[8] = '{1'b1, 1'b1, 32'h0000_0408, 32'h1234_5678,  4'hF,    7, 0, 1'b0, 1'b1, 8};
        vecs[9] = '{1'b1, 1'b1, 32'h0000_040C, 32'h8765_4321,  4'b1100, 3, 2, 1'b0, 1'b0, 7};

        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;

        // Reset held with both requesters active, data wins first, fetch follows.
        push_txn(1, 0, 32'h0000_0600, 32'h0, 4'hF, 0, 2, 0);
        push_txn(0, 0, 32'h0000_0180, 32'h0, 4'hF, 0, 2, 4);
        drive_heads();
        repeat (2) begin
            @(negedge clk);
            chk("reset_ctl", {mem_req, mem_we, mem_be, i_done, d_done, err}, 0);
            chk("reset_data", mem_addr | mem_wdata | i_rdata | d_rdata, 0);
        end
        rst = 1'b0;
        t0 = cyc;
        first_rise = -1;
        run_loop();
        chk("first_req_cycle", first_rise - t0, 1);

        for (int k = 0; k < 10; k++) begin
            cfg_gnt_lat = vecs[k].gnt_lat;
            cfg_rv_lat  = vecs[k].rv_lat;
            cfg_never   = vecs[k].never;
            push_txn(vecs[k].is_d, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].be,
                     vecs[k].exp_err, vecs[k].exp_lat, 0);
            drive_heads();
            run_loop();
        end
        cfg_gnt_lat = 0; cfg_rv_lat = 0; cfg_never = 0;

        // Collision: load wins, fetch issued in the very next IDLE.
        push_txn(1, 0, 32'h0000_2000, 32'h0, 4'hF, 0, 2, 0);
        push_txn(0, 0, 32'h0000_0110, 32'h0, 4'hF, 0, 2, 4);
        drive_heads();
        run_loop();

        // Starvation: both held, grant order D,D,D,D,I,D,D,D,D,I.
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9)
                push_txn(0, 0, 32'h0000_0200 + 32'(k), 32'h0, 4'hF, 0, 2, (k == 0) ? 0 : 4);
            else
                push_txn(1, 0, 32'h0000_5000 + 32'(k * 4), 32'h0, 4'hF, 0, 2, (k == 0) ? 0 : 4);
        end
        drive_heads();
        run_loop();

        // Stray rvalid outside WAIT must be ignored.
        cfg_stray = 1; cfg_gnt_lat = 2; cfg_rv_lat = 1;
        push_txn(0, 0, 32'h0000_0300, 32'h0, 4'hF, 0, 5, 0);
        drive_heads();
        run_loop();
        cfg_stray = 0; cfg_gnt_lat = 0; cfg_rv_lat = 0;

        // Reset in the middle of an ungranted load: no done pulse afterwards.
        cfg_never = 1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; d_be = 4'hF;
        repeat (3) @(negedge clk);
        chk("pre_reset_req", {mem_req, mem_addr}, {1'b1, 32'h0000_0500});
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("midrst_ctl", {mem_req, i_done, d_done, err}, 0);
        chk("midrst_addr", mem_addr, 0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("no_done_after_rst", {mem_req, i_done, d_done}, 0);
        end
        cfg_never = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
